// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller.
//   mc_state_e  : controller FSM states
//   mc_len_e    : LSB access length encodings
//   mc_acc_t    : access latched at acceptance (address, store data, byte count)
//   len_bytes() : length encoding -> byte count (illegal 3 treated as word)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_IFETCH = 2'd1,
        MC_LOAD   = 2'd2,
        MC_STORE  = 2'd3
    } mc_state_e;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2
    } mc_len_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  nbytes;
    } mc_acc_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (mc_len_e'(len))
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: owner of the byte-wide RAM/IO bus. Serves 4-byte instruction
// fetches and 1/2/4-byte LSB loads/stores, one byte per cycle, and returns
// one-cycle ready pulses. All outputs are registered.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze), clear_in (flush)
//   inst_req/inst_addr -> inst_data/inst_ready          fetch port
//   lsb_req/lsb_wr/lsb_addr/lsb_len/lsb_wdata
//                      -> lsb_rdata/lsb_ready           load/store port
//   mem_din / mem_dout / mem_a / mem_wr                 RAM bus
//   io_buffer_full                                      stalls IO-space writes
//
// Build option: define MEMCTRL_FAIR_ARB_EN for round-robin arbitration between
// the two ports; otherwise the LSB always wins a simultaneous request.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ready,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic [31:0] lsb_rdata,
    output logic        lsb_ready,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e   state;
    mc_acc_t     acc;
    // Reads: edges since (re)start of the access. Writes: bytes already issued.
    logic [2:0]  cnt;
    logic [31:0] rbuf;

    // ---------------- arbitration ----------------
    logic accept, grant_lsb;

`ifdef MEMCTRL_FAIR_ARB_EN
    logic last_lsb;   // port served most recently; reset value favours the LSB
    always_comb grant_lsb = lsb_req && !(inst_req && last_lsb);
`else
    always_comb grant_lsb = lsb_req;
`endif

    // No acceptance while a ready pulse is out: the requester still holds req
    // during that cycle and it must not be taken as a new request.
    always_comb accept = (state == MC_IDLE) && !clear_in && !inst_ready &&
                         !lsb_ready && (lsb_req || inst_req);

    // ---------------- store byte issue ----------------
    logic [31:0] st_addr;
    logic [7:0]  st_byte;
    logic        st_stall;

    always_comb begin
        if (state == MC_IDLE) begin
            st_addr = lsb_addr;
            st_byte = lsb_wdata[7:0];
        end else begin
            st_addr = acc.addr + {29'd0, cnt};
            st_byte = acc.wdata[{cnt[1:0], 3'b000} +: 8];
        end
        st_stall = (st_addr >= IO_BASE) && io_buffer_full;
    end

    // ---------------- read byte capture ----------------
    // mem_din lags the address by one cycle, so the byte arriving on edge cnt
    // belongs to offset cnt-2.
    logic [1:0]  cap_idx;
    logic [31:0] rd_merged;

    always_comb begin
        cap_idx   = cnt[1:0] - 2'd2;
        rd_merged = rbuf;
        rd_merged[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= MC_IDLE;
            acc        <= '0;
            cnt        <= '0;
            rbuf       <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            inst_ready <= 1'b0;
            lsb_ready  <= 1'b0;
            inst_data  <= '0;
            lsb_rdata  <= '0;
`ifdef MEMCTRL_FAIR_ARB_EN
            last_lsb   <= 1'b0;
`endif
        end else if (!rdy_in) begin
            // Freeze. A read is restarted from byte 0 because the RAM data
            // pipeline is not held; a write resumes at the next unwritten byte.
            mem_wr <= 1'b0;
            if (state == MC_IFETCH || state == MC_LOAD)
                cnt <= '0;
        end else begin
            inst_ready <= 1'b0;
            lsb_ready  <= 1'b0;
            mem_wr     <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (accept) begin
                        if (grant_lsb) begin
                            acc.addr   <= lsb_addr;
                            acc.wdata  <= lsb_wdata;
                            acc.nbytes <= len_bytes(lsb_len);
                            mem_a      <= lsb_addr;
`ifdef MEMCTRL_FAIR_ARB_EN
                            last_lsb   <= 1'b1;
`endif
                            if (lsb_wr) begin
                                state <= MC_STORE;
                                if (st_stall) begin
                                    cnt <= 3'd0;
                                end else begin
                                    mem_wr   <= 1'b1;
                                    mem_dout <= st_byte;
                                    cnt      <= 3'd1;
                                end
                            end else begin
                                state <= MC_LOAD;
                                cnt   <= 3'd1;
                                rbuf  <= '0;
                            end
                        end else begin
                            acc.addr   <= inst_addr;
                            acc.wdata  <= '0;
                            acc.nbytes <= 3'd4;
                            mem_a      <= inst_addr;
                            state      <= MC_IFETCH;
                            cnt        <= 3'd1;
                            rbuf       <= '0;
`ifdef MEMCTRL_FAIR_ARB_EN
                            last_lsb   <= 1'b0;
`endif
                        end
                    end
                end

                MC_IFETCH, MC_LOAD: begin
                    if (clear_in) begin
                        state <= MC_IDLE;
                        mem_a <= '0;
                    end else begin
                        mem_a <= (cnt < acc.nbytes) ? acc.addr + {29'd0, cnt} : '0;
                        if (cnt >= 3'd2)
                            rbuf <= rd_merged;
                        if (cnt == acc.nbytes + 3'd1) begin
                            state <= MC_IDLE;
                            if (state == MC_IFETCH) begin
                                inst_ready <= 1'b1;
                                inst_data  <= rd_merged;
                            end else begin
                                lsb_ready  <= 1'b1;
                                lsb_rdata  <= rd_merged;
                            end
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                MC_STORE: begin
                    // Stores ignore clear_in: they are already committed.
                    if (cnt == acc.nbytes) begin
                        state     <= MC_IDLE;
                        lsb_ready <= 1'b1;
                        mem_a     <= '0;
                    end else begin
                        mem_a <= st_addr;
                        if (!st_stall) begin
                            mem_wr   <= 1'b1;
                            mem_dout <= st_byte;
                            cnt      <= cnt + 3'd1;
                        end
                    end
                end

                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed + random checks of mem_ctrl against a byte-array RAM
// and a behavioural model of access results, latencies and arbitration order.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        inst_req, inst_ready;
    logic [31:0] inst_addr, inst_data;
    logic        lsb_req, lsb_wr, lsb_ready;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_ready(inst_ready), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_wdata(lsb_wdata),
        .lsb_rdata(lsb_rdata), .lsb_ready(lsb_ready), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM: 256 KiB, aliased on the low 18 address bits; read data one cycle late.
    logic [7:0] ram [0:262143];
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] = mem_dout;
    end

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ram[a[17:0]];
    endfunction

    function automatic int nb(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [1:0] len);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < nb(len); k++) r[8*k +: 8] = rb(a + 32'(k));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          frz_wr, fw_cyc;
    logic [31:0] ma_clr;

    // One access on one port, with optional clear / rdy-low / IO-full knobs
    // expressed as cycle numbers c1, c2, ... after the accept edge.
    task automatic xact(input bit inst, input bit wr, input logic [31:0] a,
                        input logic [1:0] len, input logic [31:0] wd,
                        input int clr_at, input int rdy_at, input int rdy_n,
                        input int iof_n, output logic [31:0] rd,
                        output int lat, output bit got);
        @(negedge clk_in);
        wa_q.delete(); wd_q.delete();
        frz_wr = 0; fw_cyc = 0; ma_clr = 32'hFFFF_FFFF;
        if (iof_n > 0) io_buffer_full = 1'b1;
        if (inst) begin
            inst_req = 1'b1; inst_addr = a;
        end else begin
            lsb_req = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
        end
        got = 1'b0; lat = 0; rd = '0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (cyc == clr_at + 1) ma_clr = mem_a;
            if (mem_wr) begin
                wa_q.push_back(mem_a);
                wd_q.push_back(mem_dout);
                if (fw_cyc == 0) fw_cyc = cyc;
                if (rdy_n > 0 && cyc > rdy_at && cyc <= rdy_at + rdy_n) frz_wr++;
            end
            if (inst ? inst_ready : lsb_ready) begin
                got = 1'b1; lat = cyc;
                rd = inst ? inst_data : lsb_rdata;
                inst_req = 1'b0; lsb_req = 1'b0;
            end
            if (cyc == iof_n) io_buffer_full = 1'b0;
            if (clr_at > 0 && cyc == clr_at) begin
                clear_in = 1'b1;
                if (inst || !wr) begin inst_req = 1'b0; lsb_req = 1'b0; end
            end
            if (clr_at > 0 && cyc == clr_at + 1) clear_in = 1'b0;
            if (rdy_n > 0 && cyc == rdy_at) rdy_in = 1'b0;
            if (rdy_n > 0 && cyc == rdy_at + rdy_n) rdy_in = 1'b1;
        end
        inst_req = 1'b0; lsb_req = 1'b0; clear_in = 1'b0;
        rdy_in = 1'b1; io_buffer_full = 1'b0;
    endtask

    task automatic st_check(input string tag, input logic [31:0] a, input logic [1:0] len,
                            input logic [31:0] wd, input int lat, input int exp_lat);
        int n;
        n = nb(len);
        if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_nwr"}, wa_q.size(), n);
        for (int k = 0; k < n && k < wa_q.size(); k++) begin
            chk({tag, "_addr"}, wa_q[k], a + 32'(k));
            chk({tag, "_dout"}, {24'd0, wd_q[k]}, {24'd0, wd[8*k +: 8]});
            chk({tag, "_ram"}, {24'd0, rb(a + 32'(k))}, {24'd0, wd[8*k +: 8]});
        end
    endtask

    logic [31:0] rd, a, wd, e;
    logic [1:0]  len;
    int          lat, kind;
    bit          got, fair;
    logic [31:0] la [2];
    logic [31:0] fa [2];
    int          exp_ord[$];
    int          obs_ord[$];

    initial begin
`ifdef MEMCTRL_FAIR_ARB_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        for (int i = 0; i < 262144; i++) ram[i] = 8'($urandom);
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Reset state
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_lsb_ready", {31'd0, lsb_ready}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);

        // Instruction fetch
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        xact(1, 0, 32'h100, 2'd2, 0, 0, 0, 0, 0, rd, lat, got);
        chk("fetch_got", {31'd0, got}, 32'd1);
        chk("fetch_lat", lat, 6);
        chk("fetch_data", rd, 32'h0010_0513);

        // Byte load
        ram[32'h203] = 8'hFF;
        xact(0, 0, 32'h203, 2'd0, 0, 0, 0, 0, 0, rd, lat, got);
        chk("ldb_lat", lat, 3);
        chk("ldb_data", rd, 32'h0000_00FF);

        // Word store
        xact(0, 1, 32'h400, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, rd, lat, got);
        st_check("stw", 32'h400, 2'd2, 32'hDEAD_BEEF, lat, 5);

        // Half load, and illegal length 3 read as a word
        xact(0, 0, 32'h402, 2'd1, 0, 0, 0, 0, 0, rd, lat, got);
        chk("ldh_lat", lat, 4);
        chk("ldh_data", rd, 32'h0000_DEAD);
        xact(0, 0, 32'h400, 2'd3, 0, 0, 0, 0, 0, rd, lat, got);
        chk("ld3_lat", lat, 6);
        chk("ld3_data", rd, 32'hDEAD_BEEF);

        // IO stall: full for the first 3 issue edges
        xact(0, 1, 32'h0003_0000, 2'd0, 32'h0000_005A, 0, 0, 0, 3, rd, lat, got);
        st_check("io_st", 32'h0003_0000, 2'd0, 32'h0000_005A, lat, 5);
        chk("io_first_wr", fw_cyc, 4);

        // clear_in mid-fetch (c3): no ready, bus back to idle next cycle
        xact(1, 0, 32'h120, 2'd2, 0, 3, 0, 0, 0, rd, lat, got);
        chk("clr_fetch_got", {31'd0, got}, 32'd0);
        chk("clr_fetch_mem_a", ma_clr, 32'd0);
        xact(0, 0, 32'h203, 2'd0, 0, 0, 0, 0, 0, rd, lat, got);
        chk("post_clr_lat", lat, 3);
        chk("post_clr_data", rd, 32'h0000_00FF);

        // clear_in mid word store: store still completes
        xact(0, 1, 32'h500, 2'd2, 32'h1234_5678, 2, 0, 0, 0, rd, lat, got);
        st_check("clr_st", 32'h500, 2'd2, 32'h1234_5678, lat, 5);

        // rdy_in low for 2 cycles mid word load: restart, correct word
        e = exp_rd(32'h600, 2'd2);
        xact(0, 0, 32'h600, 2'd2, 0, 0, 3, 2, 0, rd, lat, got);
        chk("rdy_ld_got", {31'd0, got}, 32'd1);
        chk("rdy_ld_data", rd, e);

        // rdy_in low mid word store: no writes while frozen, each byte once
        xact(0, 1, 32'h700, 2'd2, 32'hCAFE_F00D, 0, 2, 2, 0, rd, lat, got);
        chk("rdy_st_got", {31'd0, got}, 32'd1);
        chk("rdy_st_frozen_wr", frz_wr, 0);
        st_check("rdy_st", 32'h700, 2'd2, 32'hCAFE_F00D, lat, 0);

        // Address wrap-around
        e = exp_rd(32'hFFFF_FFFE, 2'd2);
        xact(0, 0, 32'hFFFF_FFFE, 2'd2, 0, 0, 0, 0, 0, rd, lat, got);
        chk("wrap_ld", rd, e);
        xact(0, 1, 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A, 0, 0, 0, 0, rd, lat, got);
        st_check("wrap_st", 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A, lat, 3);

        // Random traffic
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 2));
            len  = 2'($urandom_range(0, 3));
            a    = 32'($urandom_range(0, 32'h2FFF0));
            wd   = $urandom;
            if (kind == 0) begin
                a = {a[31:2], 2'b00};
                e = exp_rd(a, 2'd2);
                xact(1, 0, a, 2'd2, 0, 0, 0, 0, 0, rd, lat, got);
                chk("rnd_fetch_lat", lat, 6);
                chk("rnd_fetch_data", rd, e);
            end else if (kind == 1) begin
                e = exp_rd(a, len);
                xact(0, 0, a, len, 0, 0, 0, 0, 0, rd, lat, got);
                chk("rnd_ld_lat", lat, nb(len) + 2);
                chk("rnd_ld_data", rd, e);
            end else begin
                xact(0, 1, a, len, wd, 0, 0, 0, 0, rd, lat, got);
                st_check("rnd_st", a, len, wd, lat, nb(len) + 1);
            end
        end

        // Reset in the middle of a store
        @(negedge clk_in);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h800; lsb_len = 2'd2; lsb_wdata = 32'h0BAD_F00D;
        repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
        rst_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        lsb_req = 1'b0;
        chk("rst2_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst2_mem_a", mem_a, 32'd0);
        chk("rst2_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst2_lsb_ready", {31'd0, lsb_ready}, 32'd0);
        chk("rst2_inst_data", inst_data, 32'd0);
        chk("rst2_lsb_rdata", lsb_rdata, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Contention: both ports keep requesting, two accesses each
        la[0] = 32'h1000; la[1] = 32'h1010; fa[0] = 32'h2000; fa[1] = 32'h2010;
        begin
            int rl, ri;
            bit last_l, pick_l;
            rl = 2; ri = 2; last_l = 1'b0;
            while (rl > 0 || ri > 0) begin
                if (rl > 0 && ri > 0) pick_l = fair ? !last_l : 1'b1;
                else                  pick_l = (rl > 0);
                exp_ord.push_back(pick_l ? 0 : 1);
                if (pick_l) rl--; else ri--;
                last_l = pick_l;
            end
        end
        begin
            int nl, ni;
            nl = 0; ni = 0;
            @(negedge clk_in);
            lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = la[0];
            inst_req = 1'b1; inst_addr = fa[0];
            for (int cyc = 0; cyc < 200 && (nl < 2 || ni < 2); cyc++) begin
                @(posedge clk_in); @(negedge clk_in);
                if (lsb_ready && nl < 2) begin
                    obs_ord.push_back(0);
                    chk("cont_ld_data", lsb_rdata, exp_rd(la[nl], 2'd2));
                    nl++;
                    if (nl < 2) lsb_addr = la[nl]; else lsb_req = 1'b0;
                end
                if (inst_ready && ni < 2) begin
                    obs_ord.push_back(1);
                    chk("cont_fetch_data", inst_data, exp_rd(fa[ni], 2'd2));
                    ni++;
                    if (ni < 2) inst_addr = fa[ni]; else inst_req = 1'b0;
                end
            end
            lsb_req = 1'b0; inst_req = 1'b0;
        end
        chk("cont_count", obs_ord.size(), exp_ord.size());
        for (int k = 0; k < exp_ord.size() && k < obs_ord.size(); k++)
            chk("cont_order", obs_ord[k], exp_ord[k]);

        repeat (3) @(posedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
